// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive-side buffer placed directly after the UART receiver.
// Captures {rx_error, rx_data} on each rx_strobe into a circular buffer and
// presents the oldest word as a first-word-fall-through valid/ready stream.
// Words arriving while the buffer is full (and nothing is popped) are dropped,
// which sets a sticky overrun flag and bumps a saturating drop counter.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   rx_data/rx_error        received word and its parity-error tag
//   rx_strobe               one-cycle write strobe from the receiver
//   m_data/m_error/m_valid  head-of-buffer word, tag and valid
//   m_ready                 consumer accepts the head word
//   flush                   synchronous clear of all buffered words
//   clear_overrun           clears overrun and drop_count
//   count                   occupancy 0..DEPTH
//   almost_full             count >= ALMOST_FULL_LEVEL
//   overrun, drop_count     sticky drop flag and saturating drop counter
module uart_rx_fifo #(
  parameter int unsigned DATA_WIDTH        = 8,
  parameter int unsigned DEPTH             = 16,
  parameter int unsigned ALMOST_FULL_LEVEL = DEPTH - 2,
  parameter int unsigned DROP_COUNT_WIDTH  = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [DATA_WIDTH-1:0]       rx_data,
  input  logic                        rx_strobe,
  input  logic                        rx_error,
  output logic [DATA_WIDTH-1:0]       m_data,
  output logic                        m_error,
  output logic                        m_valid,
  input  logic                        m_ready,
  input  logic                        flush,
  input  logic                        clear_overrun,
  output logic [$clog2(DEPTH):0]      count,
  output logic                        almost_full,
  output logic                        overrun,
  output logic [DROP_COUNT_WIDTH-1:0] drop_count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [DATA_WIDTH:0]         mem_q [DEPTH];
  logic [PtrW-1:0]             wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]             count_q, count_d;
  logic                        overrun_q;
  logic [DROP_COUNT_WIDTH-1:0] drop_count_q;

  logic full, push, pop, drop;
  logic [DATA_WIDTH:0] head;

  assign full = (count_q == CntW'(DEPTH));
  assign pop  = (count_q != '0) & m_ready & ~flush;
  // A simultaneous pop frees a slot, so a strobe on a full buffer is still accepted.
  assign push = rx_strobe & ~flush & (~full | pop);
  assign drop = rx_strobe & ~flush & full & ~pop;

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {rx_error, rx_data};
    end
  end

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_d;
    end
  end

  // A drop in the same cycle as clear_overrun wins and restarts the count at 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_q    <= 1'b0;
      drop_count_q <= '0;
    end else if (drop) begin
      overrun_q <= 1'b1;
      if (clear_overrun) begin
        drop_count_q <= DROP_COUNT_WIDTH'(1);
      end else if (!(&drop_count_q)) begin
        drop_count_q <= drop_count_q + DROP_COUNT_WIDTH'(1);
      end
    end else if (clear_overrun) begin
      overrun_q    <= 1'b0;
      drop_count_q <= '0;
    end
  end

  assign head = mem_q[rd_ptr_q];

  // Head word is gated by valid so the outputs read 0 whenever the buffer is empty.
  assign m_valid     = (count_q != '0);
  assign m_data      = m_valid ? head[DATA_WIDTH-1:0] : '0;
  assign m_error     = m_valid & head[DATA_WIDTH];
  assign count       = count_q;
  assign almost_full = (count_q >= CntW'(ALMOST_FULL_LEVEL));
  assign overrun     = overrun_q;
  assign drop_count  = drop_count_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_strobe, rx_error;
  logic [7:0] m_data;
  logic       m_error, m_valid, m_ready;
  logic       flush, clear_overrun;
  logic [4:0] count;
  logic       almost_full, overrun;
  logic [7:0] drop_count;

  uart_rx_fifo dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_data      (rx_data),
    .rx_strobe    (rx_strobe),
    .rx_error     (rx_error),
    .m_data       (m_data),
    .m_error      (m_error),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .flush        (flush),
    .clear_overrun(clear_overrun),
    .count        (count),
    .almost_full  (almost_full),
    .overrun      (overrun),
    .drop_count   (drop_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a queue of {error, data} words plus overrun state.
  logic [8:0] mq[$];
  logic       m_ovr;
  int         m_drop;

  typedef struct {
    logic       s;
    logic [7:0] d;
    logic       e, r, f, c;
    logic       xv;
    logic [7:0] xd;
    logic       xe;
    logic [4:0] xc;
    logic       xaf, xo;
    logic [7:0] xdc;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_model(input string tag);
    int sz = mq.size();
    chk({tag, " m_valid"}, 32'(m_valid), 32'(sz != 0));
    chk({tag, " m_data"}, 32'(m_data), (sz != 0) ? 32'(mq[0][7:0]) : 32'd0);
    chk({tag, " m_error"}, 32'(m_error), (sz != 0) ? 32'(mq[0][8]) : 32'd0);
    chk({tag, " count"}, 32'(count), 32'(sz));
    chk({tag, " almost_full"}, 32'(almost_full), 32'(sz >= 14));
    chk({tag, " overrun"}, 32'(overrun), 32'(m_ovr));
    chk({tag, " drop_count"}, 32'(drop_count), 32'(m_drop));
  endtask

  // Drive one cycle, advance the model, sample #1 after the edge and compare.
  task automatic step(input logic s, input logic [7:0] d, input logic e,
                      input logic r, input logic f, input logic c, input string tag);
    int   sz = mq.size();
    logic pop, drop;
    rx_strobe = s; rx_data = d; rx_error = e;
    m_ready = r; flush = f; clear_overrun = c;
    pop  = (sz != 0) && r && !f;
    drop = 1'b0;
    if (f) begin
      mq.delete();
    end else begin
      if (pop) void'(mq.pop_front());
      if (s && (sz < 16 || pop)) mq.push_back({e, d});
      else if (s) drop = 1'b1;
    end
    if (drop) begin
      m_ovr  = 1'b1;
      m_drop = c ? 1 : ((m_drop == 255) ? 255 : m_drop + 1);
    end else if (c) begin
      m_ovr  = 1'b0;
      m_drop = 0;
    end
    @(posedge clk);
    #1;
    chk_model(tag);
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovr  = 1'b0;
    m_drop = 0;
  endtask

  initial begin
    logic [7:0] exp_d;
    int thr;

    //          s    d      e  r  f  c   xv xd     xe xc  af o  dc
    tbl[0]  = '{1, 8'hA5, 0, 0, 0, 0,  1, 8'hA5, 0, 1,  0, 0, 0};
    tbl[1]  = '{0, 8'h00, 0, 1, 0, 0,  0, 8'h00, 0, 0,  0, 0, 0};
    tbl[2]  = '{1, 8'h3C, 1, 0, 0, 0,  1, 8'h3C, 1, 1,  0, 0, 0};
    tbl[3]  = '{0, 8'h00, 0, 0, 0, 0,  1, 8'h3C, 1, 1,  0, 0, 0};
    tbl[4]  = '{0, 8'h00, 0, 0, 0, 0,  1, 8'h3C, 1, 1,  0, 0, 0};
    tbl[5]  = '{0, 8'h00, 0, 0, 0, 0,  1, 8'h3C, 1, 1,  0, 0, 0};
    tbl[6]  = '{0, 8'h00, 0, 0, 0, 0,  1, 8'h3C, 1, 1,  0, 0, 0};
    tbl[7]  = '{0, 8'h00, 0, 0, 0, 0,  1, 8'h3C, 1, 1,  0, 0, 0};
    tbl[8]  = '{1, 8'h11, 0, 1, 0, 0,  1, 8'h11, 0, 1,  0, 0, 0};
    tbl[9]  = '{1, 8'h22, 0, 0, 0, 0,  1, 8'h11, 0, 2,  0, 0, 0};
    tbl[10] = '{1, 8'h33, 0, 0, 1, 0,  0, 8'h00, 0, 0,  0, 0, 0};
    tbl[11] = '{0, 8'h00, 0, 1, 0, 0,  0, 8'h00, 0, 0,  0, 0, 0};

    rst_n = 1'b0;
    rx_strobe = 0; rx_data = 0; rx_error = 0;
    m_ready = 0; flush = 0; clear_overrun = 0;
    model_reset();
    #12;
    chk("reset m_valid", 32'(m_valid), 32'd0);
    chk("reset m_data", 32'(m_data), 32'd0);
    chk("reset count", 32'(count), 32'd0);
    chk("reset overrun", 32'(overrun), 32'd0);
    chk("reset drop_count", 32'(drop_count), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Table vectors: single write/read, error tag under backpressure, flush.
    for (int i = 0; i < 12; i++) begin
      step(tbl[i].s, tbl[i].d, tbl[i].e, tbl[i].r, tbl[i].f, tbl[i].c, "tbl");
      chk($sformatf("tbl%0d m_valid", i), 32'(m_valid), 32'(tbl[i].xv));
      chk($sformatf("tbl%0d m_data", i), 32'(m_data), 32'(tbl[i].xd));
      chk($sformatf("tbl%0d m_error", i), 32'(m_error), 32'(tbl[i].xe));
      chk($sformatf("tbl%0d count", i), 32'(count), 32'(tbl[i].xc));
      chk($sformatf("tbl%0d almost_full", i), 32'(almost_full), 32'(tbl[i].xaf));
      chk($sformatf("tbl%0d overrun", i), 32'(overrun), 32'(tbl[i].xo));
      chk($sformatf("tbl%0d drop_count", i), 32'(drop_count), 32'(tbl[i].xdc));
    end

    // Fill to 16, overrun, accept-while-popping at full, drain in order.
    for (int i = 0; i < 16; i++) begin
      step(1, 8'(i), 0, 0, 0, 0, "fill");
      chk("fill count", 32'(count), 32'(i + 1));
      chk("fill almost_full", 32'(almost_full), 32'(i + 1 >= 14));
    end
    step(1, 8'h55, 0, 0, 0, 0, "ovr");
    chk("ovr overrun", 32'(overrun), 32'd1);
    chk("ovr drop_count", 32'(drop_count), 32'd1);
    chk("ovr count", 32'(count), 32'd16);
    chk("ovr head", 32'(m_data), 32'h00);
    step(1, 8'h66, 0, 1, 0, 0, "fullpop");
    chk("fullpop count", 32'(count), 32'd16);
    chk("fullpop head", 32'(m_data), 32'h01);
    for (int i = 0; i < 16; i++) begin
      exp_d = (i < 15) ? 8'(i + 1) : 8'h66;
      chk("drain1 order", 32'(m_data), 32'(exp_d));
      chk("drain1 m_error", 32'(m_error), 32'd0);
      step(0, 0, 0, 1, 0, 0, "drain1");
    end
    chk("drain1 empty", 32'(m_valid), 32'd0);

    // Second fill exercises pointer wrap.
    for (int i = 0; i < 16; i++) step(1, 8'(8'h10 + i), 0, 0, 0, 0, "fill2");
    for (int i = 0; i < 16; i++) begin
      chk("drain2 order", 32'(m_data), 32'(8'h10 + i));
      step(0, 0, 0, 1, 0, 0, "drain2");
    end

    // Second drop, then flush with 7 queued plus a concurrent strobe.
    for (int i = 0; i < 16; i++) step(1, 8'(i), 0, 0, 0, 0, "fill3");
    step(1, 8'h77, 0, 0, 0, 0, "drop2");
    chk("drop2 drop_count", 32'(drop_count), 32'd2);
    step(0, 0, 0, 0, 1, 0, "flush0");
    for (int i = 0; i < 7; i++) step(1, 8'(8'h40 + i), 0, 0, 0, 0, "fill7");
    chk("fill7 count", 32'(count), 32'd7);
    step(1, 8'h99, 0, 1, 1, 0, "flush7");
    chk("flush7 count", 32'(count), 32'd0);
    chk("flush7 m_valid", 32'(m_valid), 32'd0);
    chk("flush7 drop_count", 32'(drop_count), 32'd2);
    chk("flush7 overrun", 32'(overrun), 32'd1);

    // clear_overrun together with a drop: the set wins.
    for (int i = 0; i < 16; i++) step(1, 8'(i), 0, 0, 0, 0, "fill4");
    step(1, 8'hAA, 0, 0, 0, 1, "clrdrop");
    chk("clrdrop overrun", 32'(overrun), 32'd1);
    chk("clrdrop drop_count", 32'(drop_count), 32'd1);
    step(0, 0, 0, 0, 0, 1, "clr");
    chk("clr overrun", 32'(overrun), 32'd0);
    chk("clr drop_count", 32'(drop_count), 32'd0);
    step(0, 0, 0, 0, 1, 0, "flush1");

    // Random traffic; consumer speed varies per block to reach full and empty.
    for (int b = 0; b < 16; b++) begin
      thr = $urandom_range(5, 95);
      for (int i = 0; i < 100; i++) begin
        step($urandom_range(0, 99) < 60, 8'($urandom), 1'($urandom),
             $urandom_range(0, 99) < thr, $urandom_range(0, 99) < 2,
             $urandom_range(0, 99) < 3, "rand");
      end
    end

    // Async reset mid-stream with 5 words queued and a nonzero drop count.
    step(0, 0, 0, 0, 1, 0, "flush2");
    for (int i = 0; i < 16; i++) step(1, 8'(i), 0, 0, 0, 0, "fill5");
    step(1, 8'hEE, 0, 0, 0, 0, "drop3");
    for (int i = 0; i < 11; i++) step(0, 0, 0, 1, 0, 0, "pop11");
    chk("prereset count", 32'(count), 32'd5);
    m_ready = 0;
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("async m_valid", 32'(m_valid), 32'd0);
    chk("async m_data", 32'(m_data), 32'd0);
    chk("async count", 32'(count), 32'd0);
    chk("async overrun", 32'(overrun), 32'd0);
    chk("async drop_count", 32'(drop_count), 32'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("postreset m_valid", 32'(m_valid), 32'd0);
    step(1, 8'h5A, 0, 0, 0, 0, "postreset");
    chk("postreset data", 32'(m_data), 32'h5A);
    chk("postreset count", 32'(count), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive-side buffer that sits directly downstream of the UART receiver.
- Captures each received word with its parity-error tag on the receiver's one-cycle ready strobe.
- Holds words in a circular buffer and presents them to the system as a first-word-fall-through valid/ready stream.
- Detects and counts overruns, i.e. words arriving while the buffer is full, so firmware can tell bytes were lost.

Parameters:
- DATA_WIDTH, 8, width of one received word; must equal the receiver's dataout width.
- DEPTH, 16, number of entries; must be a power of two, at least 2.
- ALMOST_FULL_LEVEL, DEPTH-2, occupancy at or above which almost_full asserts.
- DROP_COUNT_WIDTH, 8, width of the saturating dropped-word counter.

Ports:
- clk  in  1  single clock for all logic.
- rst_n  in  1  asynchronous, active-low reset.
- rx_data  in  DATA_WIDTH  received word; sampled only when rx_strobe=1.
- rx_strobe  in  1  one-cycle write strobe; connects to the receiver's uart_rx_ready.
- rx_error  in  1  parity-error flag for the same word; sampled with rx_strobe.
- m_data  out  DATA_WIDTH  head-of-buffer word.
- m_error  out  1  error tag of the head word.
- m_valid  out  1  the buffer is non-empty and m_data/m_error are valid.
- m_ready  in  1  consumer accepts the head word when m_valid=1.
- flush  in  1  synchronous clear of all buffer contents.
- clear_overrun  in  1  clears overrun and drop_count.
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- almost_full  out  1  asserted when count >= ALMOST_FULL_LEVEL.
- overrun  out  1  sticky; set when a word was dropped.
- drop_count  out  DROP_COUNT_WIDTH  saturating count of dropped words.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - wr_ptr, rd_ptr and count go to 0.
  - m_valid, almost_full, overrun and drop_count go to 0.
  - m_data and m_error go to 0.
  - Storage contents are not cleared.
  - Reset mid-stream discards all buffered words.
- Storage:
  - DEPTH entries, each {rx_error, rx_data}.
  - Pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH with no special case at wrap.
- push = rx_strobe & ~flush & (count<DEPTH | pop).
- pop = m_valid & m_ready & ~flush.
- Write timing:
  - A push writes mem[wr_ptr] at the clock edge and increments wr_ptr.
  - On an empty buffer, m_valid=1 on the cycle after the rx_strobe cycle, so write-to-valid latency is 1 clock.
- Read timing:
  - m_data/m_error = mem[rd_ptr], which is combinational from storage.
  - m_valid = (count != 0) and is registered via count.
  - A pop increments rd_ptr; the next word is presented the cycle after.
  - m_valid, m_data and m_error must remain stable while m_valid=1 and m_ready=0.
- Count update:
  - push only: count+1.
  - pop only: count-1.
  - push and pop together: count unchanged, including at count=DEPTH; the write is accepted, not dropped.
- Full and overrun:
  - If rx_strobe=1, count=DEPTH and no pop, the word is discarded and storage is unchanged.
  - On that event overrun <= 1 and drop_count increments, saturating at all-ones.
- clear_overrun:
  - Clears overrun and drop_count to 0 next cycle.
  - If a drop happens in the same cycle, the set wins: overrun=1 and drop_count=1.
- Flush:
  - Next cycle wr_ptr=rd_ptr=0, count=0 and m_valid=0.
  - Flush has priority over rx_strobe and m_ready; the concurrent word is discarded and is not counted as an overrun.
  - Flush leaves overrun and drop_count unchanged.
- almost_full is combinational from registered count.
- m_ready while m_valid=0 has no effect.
- No dependence on the UART baud timing; rx_strobe may assert on back-to-back cycles.

Test Plan:
- Reset, then single write: rx_data=0xA5, rx_error=0, one strobe -> next cycle m_valid=1, m_data=0xA5, count=1; pulse m_ready -> next cycle m_valid=0, count=0.
- Fill and order (DEPTH=16): write 0x00..0x0F with m_ready=0 -> count=16, almost_full=1 from count=14; drain with m_ready=1 -> data 0x00..0x0F in order, m_error=0; wrap is verified by a second fill of 0x10..0x1F.
- Overrun: fill to 16, strobe 0x55 with no pop -> word dropped, overrun=1, drop_count=1; then strobe 0x66 while popping -> accepted, count stays 16, and 0x66 is the last word out.
- Error tag and backpressure: write 0x3C with rx_error=1, hold m_ready=0 for 5 cycles -> m_data=0x3C and m_error=1 stable throughout.
- Flush and clear priority:
  - flush with count=7 plus simultaneous strobe -> count=0, m_valid=0, drop_count unchanged.
  - clear_overrun in the same cycle as a full drop -> overrun=1, drop_count=1.
- Async reset mid-stream: count=5, assert rst_n=0 between clock edges -> outputs go to 0 immediately; after release the first new write appears with 1-cycle latency.
